aes_decipher_core: RTL

AES_DECIPHER_CORE -- requirements
Module: aes_decipher_core

---
 rtl/aes_decipher_core.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/aes_decipher_core.sv
// AES-128 iterative decipher core: one inverse round per clock, round keys
// fetched combinationally from an external key store indexed by 'round'.

// Combinational inverse S-box lookup; entry 0x00 is the most significant byte.
module aes_inv_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);
   localparam logic [255:0][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   // The first listed byte lands at packed index 255, so index with ~in_byte.
   assign out_byte = INV_SBOX[~in_byte];
endmodule

module aes_decipher_core (
   input  logic         clk,
   input  logic         reset,
   input  logic         keys_ready,
   input  logic         next,
   input  logic [127:0] data,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   output logic [127:0] result,
   output logic         ready
);
   typedef enum logic [1:0] {IDLE, MAIN, FINAL} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [3:0]   round_q, round_d;

   logic [127:0] isr;   // InvShiftRows(state)
   logic [127:0] isb;   // InvSubBytes(InvShiftRows(state))
   logic [127:0] ark;   // ... XOR round_key
   logic [127:0] imc;   // InvMixColumns(...)

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One column of InvMixColumns using the 0e/0b/0d/09 circulant matrix.
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int k = 0; k < 4; k++) begin
         a[k]  = col[31-8*k -: 8];
         x2[k] = xtime(a[k]);
         x4[k] = xtime(x2[k]);
         x8[k] = xtime(x4[k]);
         m9[k] = x8[k] ^ a[k];
         mb[k] = x8[k] ^ x2[k] ^ a[k];
         md[k] = x8[k] ^ x4[k] ^ a[k];
         me[k] = x8[k] ^ x4[k] ^ x2[k];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // Byte gi holds row gi%4 of column gi/4; row r rotates right by r columns.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_byte
         localparam int ROW = gi % 4;
         localparam int COL = gi / 4;
         localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
         assign isr[127-8*gi -: 8] = state_q[127-8*SRC -: 8];
         aes_inv_sbox u_inv_sbox (
            .in_byte  (isr[127-8*gi -: 8]),
            .out_byte (isb[127-8*gi -: 8])
         );
      end
      for (gi = 0; gi < 4; gi++) begin : g_col
         assign imc[127-32*gi -: 32] = inv_mix_col(ark[127-32*gi -: 32]);
      end
   endgenerate

   assign ark = isb ^ round_key;

   // Next-state logic: initial key add, nine full rounds, last round without mixing.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      round_d = round_q;
      case (fsm_q)
         IDLE: begin
            if (next && keys_ready) begin
               state_d = data ^ round_key;
               round_d = 4'd9;
               fsm_d   = MAIN;
            end
         end
         MAIN: begin
            state_d = imc;
            round_d = round_q - 4'd1;
            if (round_q == 4'd1) begin
               fsm_d = FINAL;
            end
         end
         FINAL: begin
            state_d = ark;
            round_d = 4'd10;
            fsm_d   = IDLE;
         end
         default: begin
            fsm_d   = IDLE;
            round_d = 4'd10;
         end
      endcase
   end

   // State registers; reset wins over any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         round_q <= 4'd10;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         round_q <= round_d;
      end
   end

   assign round  = round_q;
   assign result = state_q;
   assign ready  = (fsm_q == IDLE);
endmodule
